store_rmw_writer: RTL and testbench
===================================

Name: store_rmw_writer

Overview:
- Memory-stage store writer. Performs SB/SH/SW stores into a word-wide synchronous data RAM that has no byte enables.
- Sub-word stores use a read-modify-write sequence.
- It is the write-side counterpart of the write-back load-halfword-unsigned data path.
- It sits between the MEM-stage pipeline register and the data RAM port, and stalls the pipeline while busy.

Parameters:
- AddrBits, 12, word-address width of the data RAM; the byte address is AddrBits+2 bits.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  store request from the MEM stage; sampled only while Ready=1.
- Addr  in  AddrBits+2  byte address.
- Data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- Size  in  2  store size: 0=byte, 1=half, 2=word, 3=reserved.
- Ready  out  1  1 when in IDLE; the pipeline stalls on Req & !Ready.
- Done  out  1  one-cycle pulse in the cycle the RAM write occurs.
- Err  out  1  one-cycle pulse for a misaligned or reserved-size request.
- MemAddr  out  AddrBits  RAM word address.
- MemRe  out  1  RAM read enable; read data is valid on MemRdata the following cycle.
- MemRdata  in  32  RAM read data.
- MemWe  out  1  RAM write enable.
- MemWdata  out  32  RAM write data.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - Ready=1; Done, Err, MemRe and MemWe = 0.
  - MemAddr and MemWdata = 0.
  - All latched registers cleared.
- Little-endian lanes:
  - byte lane = Addr[1:0].
  - half lane = Addr[1]; Addr[1]=0 selects bits [15:0], Addr[1]=1 selects bits [31:16].
- State machine, one-hot or binary: IDLE, READ, MERGE, WRITE.
- IDLE:
  - On Req: latch word address Addr[AddrBits+1:2], Data, Size and lane.
  - Size=2 and Addr[1:0]==0 -> WRITE.
  - Size=0 -> READ.
  - Size=1 and Addr[0]==0 -> READ.
  - Misaligned request (Size=1 with Addr[0]=1, or Size=2 with Addr[1:0]!=0) or Size=3 -> Err=1 next cycle, stay IDLE, no RAM access.
- READ: MemRe=1 and MemAddr=latched word address for one cycle -> MERGE.
- MERGE:
  - Merge register = MemRdata with the selected lane(s) replaced by Data[7:0] (byte) or Data[15:0] (half).
  - Other lanes are unchanged bit-for-bit.
  - -> WRITE.
- WRITE:
  - MemWe=1, MemAddr=latched word address.
  - MemWdata = merge register, or latched Data for a word store.
  - Done=1 -> IDLE.
- Latency, with the request accepted at cycle T:
  - Word store: MemWe and Done at T+1; Ready returns at T+2.
  - Sub-word store: MemRe at T+1, MemWe and Done at T+3; Ready returns at T+4.
- MemRe and MemWe are never asserted in the same cycle.
- MemAddr is held stable from READ through WRITE.
- Req while Ready=0 is ignored; the pipeline holds the request until it is accepted.
- Reset during READ or MERGE: no write occurs.
- Reset during WRITE: the write may or may not complete; the bench must not check RAM contents in that case.
- The RAM has no writer other than this block.

Optional Feature:
- Macro: STORE_RMW_BYPASS_EN.
- Defined:
  - The block keeps a cached copy of the last written word: valid bit, word address and data, updated in every WRITE.
  - A sub-word request whose word address equals the cached address while valid=1 skips READ.
  - On such a hit, the merge is computed from the cached data in the cycle after accept, and the block goes directly to WRITE.
  - Hit latency: MemWe and Done at T+1.
  - The valid bit is cleared by reset.
- Undefined: no cache; every sub-word store takes the full READ/MERGE/WRITE path.

Test Plan:
- Reset low mid-READ of an SB to word 0x010, then release -> no MemWe asserted, Ready=1, Done=0, all outputs 0 during reset.
- SW Addr=0x040, Data=0xDEADBEEF, accepted at T -> MemWe=1 at T+1 with MemAddr=0x010 and MemWdata=0xDEADBEEF; Done at T+1; Ready=1 at T+2.
- RAM[0x010]=0x11223344; SH Addr=0x042, Data=0x0000ABCD -> MemRe at T+1; MemWe at T+3 with MemWdata=0xABCD3344.
- RAM[0x010]=0x11223344; SB Addr=0x041, Data=0x000000EE -> MemWdata=0x1122EE44; Done only at T+3.
- SH Addr=0x043, then Size=3 Addr=0x040 -> Err one-cycle pulse for each; no MemRe or MemWe; Ready stays 1.
- With STORE_RMW_BYPASS_EN: SW Addr=0x040, Data=0x00000000, then SB Addr=0x043, Data=0x7F -> second store has no MemRe and MemWe at T+1 with MemWdata=0x7F000000. Without the macro -> MemRe at T+1 and the same MemWdata at T+3.

Source files
------------

// File: rtl/store_rmw_writer.sv
// store_rmw_writer
//   Memory-stage store writer for a word-wide synchronous data RAM with no
//   byte enables. Word stores are written directly; byte and halfword stores
//   read the target word, merge the new lane(s) in, and write the word back.
//   The pipeline stalls on req_i & !ready_o.
//
//   Optional feature macro: STORE_RMW_BYPASS_EN
//     When defined, the last written word (address + data) is cached so a
//     sub-word store to the same word skips the RAM read.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        store request (sampled while ready_o=1)
//   addr_i       byte address, AddrBits+2 bits
//   data_i       right-aligned store data
//   size_i       0=byte, 1=half, 2=word, 3=reserved
//   ready_o      1 in IDLE
//   done_o       pulse in the cycle the RAM write occurs
//   err_o        pulse for misaligned or reserved-size request
//   mem_addr_o   RAM word address
//   mem_re_o     RAM read enable (data valid on mem_rdata_i next cycle)
//   mem_rdata_i  RAM read data
//   mem_we_o     RAM write enable
//   mem_wdata_o  RAM write data
//
// state | meaning
// IDLE  | ready for a request
// READ  | RAM read of the target word issued
// MERGE | read data present; merge new lane(s) into it
// WRITE | RAM write of the final word, done pulse
module store_rmw_writer #(
  parameter int AddrBits = 12
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [AddrBits+1:0] addr_i,
  input  logic [31:0]         data_i,
  input  logic [1:0]          size_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                err_o,
  output logic [AddrBits-1:0] mem_addr_o,
  output logic                mem_re_o,
  input  logic [31:0]         mem_rdata_i,
  output logic                mem_we_o,
  output logic [31:0]         mem_wdata_o
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_e;

  state_e      state_q;
  logic [15:0] data_q;
  logic [1:0]  lane_q;
  logic        byte_q;

  // Replace the addressed byte or halfword of word, keeping all other bits.
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [15:0] d,
                                        input logic        is_byte,
                                        input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (is_byte)      r[{lane, 3'b000} +: 8] = d[7:0];
    else if (lane[1]) r[31:16] = d;
    else              r[15:0]  = d;
    return r;
  endfunction

  logic [AddrBits-1:0] waddr;
  logic                is_byte;
  logic                word_ok;
  logic                sub_ok;
  logic [31:0]         merge_d;

  assign waddr   = addr_i[AddrBits+1:2];
  assign is_byte = (size_i == 2'd0);
  assign word_ok = (size_i == 2'd2) && (addr_i[1:0] == 2'b00);
  assign sub_ok  = is_byte || ((size_i == 2'd1) && !addr_i[0]);
  assign merge_d = merge(mem_rdata_i, data_q, byte_q, lane_q);

`ifdef STORE_RMW_BYPASS_EN
  logic                cache_vld_q;
  logic [AddrBits-1:0] cache_addr_q;
  logic [31:0]         cache_data_q;
  logic                hit;
  logic [31:0]         hit_merge_d;

  assign hit         = cache_vld_q && (cache_addr_q == waddr);
  assign hit_merge_d = merge(cache_data_q, data_i[15:0], is_byte, addr_i[1:0]);

  // The RAM has no other writer, so the word seen in WRITE stays current.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else if (state_q == WRITE) begin
      cache_vld_q  <= 1'b1;
      cache_addr_q <= mem_addr_o;
      cache_data_q <= mem_wdata_o;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      lane_q      <= '0;
      byte_q      <= 1'b0;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_addr_o  <= '0;
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
    end else begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      mem_re_o <= 1'b0;
      mem_we_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            data_q <= data_i[15:0];
            lane_q <= addr_i[1:0];
            byte_q <= is_byte;
            if (word_ok) begin
              mem_addr_o  <= waddr;
              mem_wdata_o <= data_i;
              mem_we_o    <= 1'b1;
              done_o      <= 1'b1;
              ready_o     <= 1'b0;
              state_q     <= WRITE;
            end else if (sub_ok) begin
              mem_addr_o <= waddr;
              ready_o    <= 1'b0;
`ifdef STORE_RMW_BYPASS_EN
              if (hit) begin
                mem_wdata_o <= hit_merge_d;
                mem_we_o    <= 1'b1;
                done_o      <= 1'b1;
                state_q     <= WRITE;
              end else begin
                mem_re_o <= 1'b1;
                state_q  <= READ;
              end
`else
              mem_re_o <= 1'b1;
              state_q  <= READ;
`endif
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        READ: state_q <= MERGE;
        MERGE: begin
          mem_wdata_o <= merge_d;
          mem_we_o    <= 1'b1;
          done_o      <= 1'b1;
          state_q     <= WRITE;
        end
        WRITE: begin
          ready_o <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_writer.sv
module tb_store_rmw_writer;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic [AW+1:0] addr_i = '0;
  logic [31:0]   data_i = '0;
  logic [1:0]    size_i = '0;
  logic          ready_o, done_o, err_o, mem_re_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_rdata_i = '0;
  logic [31:0]   mem_wdata_o;

  always #5 clk = ~clk;

  store_rmw_writer #(.AddrBits(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
    .data_i(data_i), .size_i(size_i), .ready_o(ready_o), .done_o(done_o),
    .err_o(err_o), .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o),
    .mem_rdata_i(mem_rdata_i), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o)
  );

  // Reference word memory (what RAM must hold) and the bench RAM itself.
  logic [31:0] mdl [64];
  logic [31:0] ram [64];

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) ram[i] <= mdl[i];
    end else begin
      if (mem_re_o) mem_rdata_i <= ram[mem_addr_o[5:0]];
      if (mem_we_o) ram[mem_addr_o[5:0]] <= mem_wdata_o;
    end
  end

  int checks = 0, errors = 0, cyc = 0;

  // Expected events keyed by cycle number.
  bit          exp_re   [int];
  bit          exp_err  [int];
  logic [11:0] exp_addr [int];
  logic [31:0] exp_wd   [int];
  int          busy_until = 0;
  bit          c_vld = 1'b0;
  logic [11:0] c_addr = '0;
  int          undo_cyc = -1;
  logic [5:0]  undo_idx = '0;
  logic [31:0] undo_old = '0;

  int          obs_re_cyc = -1, obs_we_cyc = -1, obs_done_cyc = -1, obs_err_cnt = 0;
  logic [31:0] obs_wdata = '0;
  logic [11:0] obs_waddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    bit re_e, we_e;
    re_e = exp_re.exists(cyc);
    we_e = exp_wd.exists(cyc);
    chk("ready", 32'(ready_o), 32'(cyc >= busy_until));
    chk("mem_re", 32'(mem_re_o), 32'(re_e));
    chk("mem_we", 32'(mem_we_o), 32'(we_e));
    chk("done", 32'(done_o), 32'(we_e));
    chk("err", 32'(err_o), 32'(exp_err.exists(cyc)));
    if (exp_addr.exists(cyc)) chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr[cyc]));
    if (we_e) chk("mem_wdata", mem_wdata_o, exp_wd[cyc]);
    if (mem_re_o === 1'b1) obs_re_cyc = cyc;
    if (mem_we_o === 1'b1) begin
      obs_we_cyc = cyc;
      obs_wdata  = mem_wdata_o;
      obs_waddr  = mem_addr_o;
    end
    if (done_o === 1'b1) obs_done_cyc = cyc;
    if (err_o === 1'b1) obs_err_cnt++;
  endtask

  task automatic model_accept(input logic [13:0] a, input logic [31:0] d, input logic [1:0] s);
    logic [11:0] wa;
    logic [5:0]  idx;
    logic [31:0] nw;
    int          wcyc;
    bit          hit;
    wa  = a[13:2];
    idx = wa[5:0];
    if (s == 2'd2 && a[1:0] == 2'd0) begin
      nw   = d;
      wcyc = cyc + 1;
    end else if (s == 2'd0 || (s == 2'd1 && a[0] == 1'b0)) begin
      if (s == 2'd0)
        nw = (mdl[idx] & ~(32'hFF << (8 * a[1:0]))) | ((d & 32'hFF) << (8 * a[1:0]));
      else
        nw = (mdl[idx] & ~(32'hFFFF << (16 * a[1]))) | ((d & 32'hFFFF) << (16 * a[1]));
`ifdef STORE_RMW_BYPASS_EN
      hit = c_vld && (c_addr == wa);
`else
      hit = 1'b0;
`endif
      if (hit) wcyc = cyc + 1;
      else begin
        wcyc = cyc + 3;
        exp_re[cyc+1] = 1'b1;
      end
    end else begin
      exp_err[cyc+1] = 1'b1;
      return;
    end
    for (int k = cyc + 1; k <= wcyc; k++) exp_addr[k] = wa;
    exp_wd[wcyc] = nw;
    busy_until   = wcyc + 1;
    undo_cyc     = wcyc;
    undo_idx     = idx;
    undo_old     = mdl[idx];
    mdl[idx]     = nw;
    c_vld        = 1'b1;
    c_addr       = wa;
  endtask

  // Called in the cycle after the tick that observed it; cyc is the next cycle.
  task automatic model_reset();
    exp_re.delete();
    exp_err.delete();
    exp_addr.delete();
    exp_wd.delete();
    busy_until = cyc;
    c_vld = 1'b0;
    if (undo_cyc >= cyc) begin
      mdl[undo_idx] = undo_old;
      undo_cyc = -1;
    end
  endtask

  task automatic tick(input bit r, input logic [13:0] a, input logic [31:0] d,
                      input logic [1:0] s, output bit acc);
    @(negedge clk);
    check_cycle();
    req_i  = r;
    addr_i = a;
    data_i = d;
    size_i = s;
    acc = r && (cyc >= busy_until);
    if (acc) model_accept(a, d, s);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(1'b0, '0, '0, '0, acc);
  endtask

  task automatic store(input logic [13:0] a, input logic [31:0] d, input logic [1:0] s,
                       output int t);
    bit acc;
    acc = 1'b0;
    t = -1;
    for (int n = 0; n < 20 && !acc; n++) begin
      t = cyc;
      tick(1'b1, a, d, s, acc);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  initial begin
    int t, e0, we0, re0, t0;
    bit acc, pend;
    logic [13:0] pa;
    logic [31:0] pd;
    logic [1:0]  ps;
    int r;

    for (int i = 0; i < 64; i++) mdl[i] = $urandom;
    idle(3);
    #1 rst_ni = 1'b1;
    idle(2);

    // Reset in the READ cycle of an SB to word 0x010.
    store(14'h040, 32'h55, 2'd0, t);
    idle(1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_re", 32'(mem_re_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    model_reset();
    idle(2);
    #1 rst_ni = 1'b1;
    idle(4);
    chk("rst_no_write", 32'(obs_we_cyc), 32'hFFFFFFFF);

    // SW 0x040 DEADBEEF
    store(14'h040, 32'hDEADBEEF, 2'd2, t);
    idle(3);
    chk("sw_we_cyc", 32'(obs_we_cyc), 32'(t + 1));
    chk("sw_done_cyc", 32'(obs_done_cyc), 32'(t + 1));
    chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
    chk("sw_waddr", 32'(obs_waddr), 32'h010);

    // SH 0x042 over 0x11223344
    store(14'h040, 32'h11223344, 2'd2, t);
    idle(2);
    store(14'h042, 32'h0000ABCD, 2'd1, t);
    idle(5);
    chk("sh_wdata", obs_wdata, 32'hABCD3344);
`ifdef STORE_RMW_BYPASS_EN
    chk("sh_we_cyc", 32'(obs_we_cyc), 32'(t + 1));
`else
    chk("sh_re_cyc", 32'(obs_re_cyc), 32'(t + 1));
    chk("sh_we_cyc", 32'(obs_we_cyc), 32'(t + 3));
`endif

    // SB 0x041 over 0x11223344
    store(14'h040, 32'h11223344, 2'd2, t);
    idle(2);
    store(14'h041, 32'h000000EE, 2'd0, t);
    idle(5);
    chk("sb_wdata", obs_wdata, 32'h1122EE44);
`ifdef STORE_RMW_BYPASS_EN
    chk("sb_done_cyc", 32'(obs_done_cyc), 32'(t + 1));
`else
    chk("sb_done_cyc", 32'(obs_done_cyc), 32'(t + 3));
`endif

    // Misaligned half, reserved size
    e0 = obs_err_cnt; we0 = obs_we_cyc; re0 = obs_re_cyc;
    store(14'h043, 32'h1234, 2'd1, t);
    store(14'h040, 32'h1234, 2'd3, t);
    idle(3);
    chk("err_count", 32'(obs_err_cnt - e0), 32'd2);
    chk("err_no_we", 32'(obs_we_cyc), 32'(we0));
    chk("err_no_re", 32'(obs_re_cyc), 32'(re0));

    // SW 0 then SB 0x043 7F
    store(14'h040, 32'h00000000, 2'd2, t);
    idle(2);
    re0 = obs_re_cyc;
    store(14'h043, 32'h0000007F, 2'd0, t);
    idle(5);
    chk("byp_wdata", obs_wdata, 32'h7F000000);
`ifdef STORE_RMW_BYPASS_EN
    chk("byp_no_re", 32'(obs_re_cyc), 32'(re0));
    chk("byp_we_cyc", 32'(obs_we_cyc), 32'(t + 1));
`else
    chk("byp_re_cyc", 32'(obs_re_cyc), 32'(t + 1));
    chk("byp_we_cyc", 32'(obs_we_cyc), 32'(t + 3));
`endif

    // Randomized traffic; a pending request is held until accepted.
    pend = 1'b0; pa = '0; pd = '0; ps = '0; t0 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        if ($urandom_range(0, 1) == 0) pa = {pa[13:2], 2'($urandom_range(0, 3))};
        else pa = 14'($urandom_range(0, 255));
        pd = $urandom;
        r  = int'($urandom_range(0, 9));
        ps = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      end
      tick(pend, pa, pd, ps, acc);
      if (acc) begin
        pend = 1'b0;
        t0++;
      end
    end
    idle(6);
    for (int i = 0; i < 64; i++) chk("ram_final", ram[i], mdl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
